audio_playback_ctrl: RTL
========================

AUDIO_PLAYBACK_CTRL -- requirements
Module: audio_playback_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, meaning the memory word-address width.
REQ-002 The block SHALL have parameter LEN_W, default 18, meaning the clip-length (word count) width.
REQ-003 The block SHALL have one clock and an active-low asynchronous reset: clock (input, 1, rising-edge clock) and reset_n (input, 1, async active-low reset).
REQ-004 start  input  1  one-cycle request to begin playback.
REQ-005 stop  input  1  one-cycle request to abort playback.
REQ-006 loop_en  input  1  restart at base_addr after last word; sampled continuously.
REQ-007 base_addr  input  ADDR_W  first word address; sampled on accepted start.
REQ-008 num_words  input  LEN_W  clip length in words; sampled on accepted start.
REQ-009 mem_req/mem_addr  output  1/ADDR_W  memory read request and word address.
REQ-010 mem_ack/mem_rdata  input  1/16  read acknowledge and read data, valid in ack cycle.
REQ-011 ser_enable/ser_data  output  1/16  serializer enable and current 16-bit word.
REQ-012 ser_done  input  1  serializer pulse marking the current word as fully shifted.
REQ-013 busy, finished, underrun  output  1 each  state not IDLE; end-of-clip pulse; starved-word pulse.

Function
REQ-014 FSM states SHALL be IDLE, FETCH0 and PLAY.
- IDLE->FETCH0: start=1, stop=0, num_words!=0.
- FETCH0->PLAY: first mem_ack.
REQ-015 start SHALL be ignored when num_words==0 or state!=IDLE.
REQ-016 stop SHALL take priority over every other event and force IDLE on the next edge from any state.
REQ-017 mem_req SHALL assert the cycle after entry to FETCH0, hold mem_addr stable until mem_ack, and drop the cycle after mem_ack; at most one request outstanding.
REQ-018 mem_rdata SHALL be captured only in a cycle with mem_req=1 and mem_ack=1; mem_ack in IDLE or without mem_req SHALL be ignored.
REQ-019 On the FETCH0 ack, cur word <= mem_rdata, and ser_enable SHALL rise the following cycle with ser_data = that word.
REQ-020 In PLAY, a one-word prefetch register (next_valid flag) SHALL be refilled by a new request whenever next_valid=0 and fetched-words < num_words, or loop_en=1.
REQ-021 On ser_done with next_valid=1: cur <= next and next_valid <= 0, effective the next cycle.
REQ-022 On ser_done, mem_ack in the same cycle and next_valid=0: cur <= mem_rdata directly (bypass), with no underrun.
REQ-023 On ser_done with no word available: underrun pulses 1 cycle, cur <= 16'h0000 (silence), and the pending word is played when it arrives; the word count is not advanced.
REQ-024 Addresses SHALL increment by 1 modulo 2^ADDR_W; after word num_words-1 with loop_en=1, the next fetch address SHALL be base_addr.
REQ-025 On ser_done of the last word with loop_en=0: finished pulses 1 cycle, ser_enable deasserts, state returns to IDLE.
REQ-026 busy = (state!=IDLE); ser_enable = (state==PLAY).

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE with mem_req=0, mem_addr=0, ser_enable=0, ser_data=0, busy=0, finished=0, underrun=0, next_valid=0 and counters=0.
REQ-028 Reset mid-transfer SHALL abandon any outstanding request; a later mem_ack SHALL be ignored.

Structure
REQ-029 Shared package audio_pkg SHALL hold the state enum, AUDIO_W=16 and the default ADDR_W/LEN_W constants.
REQ-030 Address/word-count generation SHALL be one sub-module, audio_addr_gen (load, advance, wrap, last flag); everything else stays in this block.

Verification
REQ-031 base=0x100, num=3, loop=0, mem ack 1 cycle after req, ser_done every 16 cycles -> addresses 0x100,0x101,0x102; ser_data sequence matches memory; finished pulses once; busy ends.
REQ-032 num_words=0, start -> busy stays 0, no mem_req.
REQ-033 num=2, loop=1 -> fetch addresses 0x100,0x101,0x100,0x101...; finished never pulses.
REQ-034 mem_ack delayed 40 cycles for word 2 -> underrun pulses on ser_done, ser_data=0x0000 for that word, then word 2 plays; no word skipped.
REQ-035 stop asserted while mem_req=1, then mem_ack arrives -> IDLE next cycle, ack ignored, ser_enable=0.
REQ-036 start and stop in the same cycle -> remains IDLE; reset_n pulled low in PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback controller slice.
package audio_pkg;

  localparam int unsigned AUDIO_W        = 16;
  localparam int unsigned DEFAULT_ADDR_W = 18;
  localparam int unsigned DEFAULT_LEN_W  = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/audio_playback_ctrl_if.sv
// Memory read bus and serializer link between the playback controller and its peers.
interface audio_playback_ctrl_if
  import audio_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [AUDIO_W-1:0] mem_rdata;
  logic               ser_enable;
  logic [AUDIO_W-1:0] ser_data;
  logic               ser_done;

  modport master (
    output mem_req, mem_addr, ser_enable, ser_data,
    input  mem_ack, mem_rdata, ser_done
  );

  modport slave (
    input  mem_req, mem_addr, ser_enable, ser_data,
    output mem_ack, mem_rdata, ser_done
  );

endinterface

// File: rtl/audio_addr_gen.sv
// Fetch address and word-index generator: load on start, advance per fetched word, wrap at clip end.
module audio_addr_gen
  import audio_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int LEN_W  = DEFAULT_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              advance,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              exhausted
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  idx;

  assign last = (idx == num_q - LEN_W'(1));

  // Wrapping to base is unconditional; exhausted only blocks further fetches
  // while loop_en is low, so raising loop_en later resumes from base.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      num_q     <= '0;
      idx       <= '0;
      addr      <= '0;
      exhausted <= 1'b0;
    end else if (load) begin
      base_q    <= base_addr;
      num_q     <= num_words;
      idx       <= '0;
      addr      <= base_addr;
      exhausted <= 1'b0;
    end else if (advance) begin
      if (last) begin
        addr      <= base_q;
        idx       <= '0;
        exhausted <= !loop_en;
      end else begin
        addr      <= addr + ADDR_W'(1);
        idx       <= idx + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_playback_ctrl.sv
// Audio clip playback: fetches 16-bit words from memory, keeps one word prefetched, feeds the serializer.
module audio_playback_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int LEN_W  = DEFAULT_LEN_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      num_words,
  audio_playback_ctrl_if.master bus,
  output logic                  busy,
  output logic                  finished,
  output logic                  underrun
);

  state_t             state;
  logic [AUDIO_W-1:0] cur;
  logic [AUDIO_W-1:0] next_word;
  logic               next_valid;
  logic               cur_last;
  logic               next_last;
  logic               ag_last;
  logic               ag_exhausted;
  logic               accept_start;
  logic               ack;
  logic               can_fetch;

  assign accept_start = (state == IDLE) && start && !stop && (num_words != '0);
  assign ack          = bus.mem_req && bus.mem_ack;
  assign can_fetch    = !ag_exhausted || loop_en;
  assign bus.ser_data = cur;

  audio_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept_start),
    .base_addr (base_addr),
    .num_words (num_words),
    .advance   (ack && !stop),
    .loop_en   (loop_en),
    .addr      (bus.mem_addr),
    .last      (ag_last),
    .exhausted (ag_exhausted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.mem_req    <= 1'b0;
      bus.ser_enable <= 1'b0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      underrun       <= 1'b0;
      cur            <= '0;
      next_word      <= '0;
      next_valid     <= 1'b0;
      cur_last       <= 1'b0;
      next_last      <= 1'b0;
    end else begin
      finished <= 1'b0;
      underrun <= 1'b0;
      if (stop) begin
        state          <= IDLE;
        busy           <= 1'b0;
        bus.ser_enable <= 1'b0;
        bus.mem_req    <= 1'b0;
        next_valid     <= 1'b0;
        cur            <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept_start) begin
              state <= FETCH0;
              busy  <= 1'b1;
            end
          end
          FETCH0: begin
            if (ack) begin
              bus.mem_req    <= 1'b0;
              cur            <= bus.mem_rdata;
              cur_last       <= ag_last;
              state          <= PLAY;
              bus.ser_enable <= 1'b1;
            end else begin
              bus.mem_req <= 1'b1;
            end
          end
          PLAY: begin
            if (bus.ser_done && cur_last && !loop_en) begin
              state          <= IDLE;
              busy           <= 1'b0;
              bus.ser_enable <= 1'b0;
              bus.mem_req    <= 1'b0;
              next_valid     <= 1'b0;
              finished       <= 1'b1;
              cur            <= '0;
            end else begin
              // A request is only issued with next_valid low, so ack never collides with a full prefetch slot.
              if (bus.ser_done) begin
                if (next_valid) begin
                  cur        <= next_word;
                  cur_last   <= next_last;
                  next_valid <= 1'b0;
                end else if (ack) begin
                  cur      <= bus.mem_rdata;
                  cur_last <= ag_last;
                end else begin
                  cur      <= '0;
                  cur_last <= 1'b0;
                  underrun <= 1'b1;
                end
              end else if (ack) begin
                next_word  <= bus.mem_rdata;
                next_last  <= ag_last;
                next_valid <= 1'b1;
              end
              if (ack) begin
                bus.mem_req <= 1'b0;
              end else if (!bus.mem_req && !next_valid && can_fetch) begin
                bus.mem_req <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
